// File: rtl/sw_alloc_rr_if.sv
// Allocator-side bundle: per-input flit requests and downstream credits in,
// per-input grants, crossbar selects and per-output lock flags out.
interface sw_alloc_rr_if #(
  parameter int NPORT = 5,
  parameter int IDW   = 3,
  parameter int EMPW  = 3
);
  logic [NPORT-1:0]      req;
  logic [NPORT-1:0]      head;
  logic [NPORT-1:0]      tail;
  logic [NPORT*IDW-1:0]  dest;
  logic [NPORT*EMPW-1:0] empl;
  logic [NPORT-1:0]      grant;
  logic [NPORT-1:0]      out_valid;
  logic [NPORT*IDW-1:0]  out_sel;
  logic [NPORT-1:0]      alloc;

  modport master (
    output req, head, tail, dest, empl,
    input  grant, out_valid, out_sel, alloc
  );

  modport slave (
    input  req, head, tail, dest, empl,
    output grant, out_valid, out_sel, alloc
  );
endinterface

// File: rtl/sw_alloc_rr.sv
// Wormhole switch allocator for the 5-port mesh router. One arbiter per
// output port runs in parallel; each holds its output for a whole packet
// once a multi-flit head wins, and uses its own round-robin pointer.

// Single-output arbiter: IDLE round-robin among eligible heads, LOCKED
// forwarding of the owning input's flits until its tail passes.
module sw_alloc_out #(
  parameter int NPORT = 5,
  parameter int IDW   = 3,
  parameter int EMPW  = 3,
  parameter int OIDX  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORT-1:0]          req,
  input  logic [NPORT-1:0]          head,
  input  logic [NPORT-1:0]          tail,
  input  logic [NPORT-1:0][IDW-1:0] dest,
  input  logic [EMPW-1:0]           empl,
  input  logic [NPORT-1:0]          busy,
  output logic [NPORT-1:0]          gnt,
  output logic                      valid,
  output logic [IDW-1:0]            sel,
  output logic                      locked,
  output logic [IDW-1:0]            owner
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, nxt_state;
  logic [IDW-1:0]   owner_q, nxt_owner;
  logic [IDW-1:0]   ptr_q, nxt_ptr;
  logic [NPORT-1:0] cand;
  logic             found;
  logic [IDW-1:0]   win;

  // A head is a candidate only if it targets this output and its input is
  // not already streaming a packet through some other output.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NPORT; i++)
      cand[i] = req[i] & head[i] & (dest[i] == IDW'(OIDX)) & ~busy[i];
  end

  // Grant selection and next-state; reset forces the comb outputs quiet.
  always_comb begin
    gnt       = '0;
    valid     = 1'b0;
    sel       = '0;
    found     = 1'b0;
    win       = '0;
    nxt_state = state;
    nxt_owner = owner_q;
    nxt_ptr   = ptr_q;
    if (!reset) begin
      if (state == LOCKED) begin
        // Owner flits go here regardless of their dest/head bits.
        if (req[owner_q] && empl != '0) begin
          gnt[owner_q] = 1'b1;
          valid        = 1'b1;
          sel          = owner_q;
          if (tail[owner_q]) nxt_state = IDLE;
        end
      end else if (empl != '0) begin
        // Scan ptr, ptr+1, ... wrapping at NPORT; first candidate wins.
        for (int k = 0; k < NPORT; k++) begin
          if (!found && cand[(int'(ptr_q) + k) % NPORT]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr_q) + k) % NPORT);
          end
        end
        if (found) begin
          gnt[win] = 1'b1;
          valid    = 1'b1;
          sel      = win;
          nxt_ptr  = (win == IDW'(NPORT - 1)) ? '0 : win + 1'b1;
          // Single-flit packets never take the lock.
          if (!tail[win]) begin
            nxt_state = LOCKED;
            nxt_owner = win;
          end
        end
      end
    end
  end

  // Lock state, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state   <= nxt_state;
      owner_q <= nxt_owner;
      ptr_q   <= nxt_ptr;
    end
  end

  assign locked = (state == LOCKED);
  assign owner  = owner_q;
endmodule

module sw_alloc_rr #(
  parameter int NPORT = 5,
  parameter int IDW   = 3,
  parameter int EMPW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  sw_alloc_rr_if.slave  bus
);
  logic [NPORT-1:0][IDW-1:0]   dest_a;
  logic [NPORT-1:0][EMPW-1:0]  empl_a;
  logic [NPORT-1:0][NPORT-1:0] gnt_a;
  logic [NPORT-1:0][IDW-1:0]   sel_a;
  logic [NPORT-1:0][IDW-1:0]   owner_a;
  logic [NPORT-1:0]            valid_a;
  logic [NPORT-1:0]            locked_a;
  logic [NPORT-1:0]            busy;
  logic [NPORT-1:0]            grant_v;

  // Flat bus fields share the packed-array bit layout (field i at [IDW*i +: IDW]).
  assign dest_a = bus.dest;
  assign empl_a = bus.empl;

  // An input is busy while any locked output names it as owner.
  always_comb begin
    busy = '0;
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        if (locked_a[o] && owner_a[o] == IDW'(i)) busy[i] = 1'b1;
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    sw_alloc_out #(
      .NPORT(NPORT), .IDW(IDW), .EMPW(EMPW), .OIDX(o)
    ) u_out (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.req),
      .head   (bus.head),
      .tail   (bus.tail),
      .dest   (dest_a),
      .empl   (empl_a[o]),
      .busy   (busy),
      .gnt    (gnt_a[o]),
      .valid  (valid_a[o]),
      .sel    (sel_a[o]),
      .locked (locked_a[o]),
      .owner  (owner_a[o])
    );
  end

  // Each input targets one output at most, so OR-ing per-output grants is exact.
  always_comb begin
    grant_v = '0;
    for (int o = 0; o < NPORT; o++) grant_v = grant_v | gnt_a[o];
  end

  assign bus.grant     = grant_v;
  assign bus.out_valid = valid_a;
  assign bus.out_sel   = sel_a;
  assign bus.alloc     = locked_a;
endmodule

// File: tb/tb_sw_alloc_rr.sv
// Bench for sw_alloc_rr: directed cycle table for the packet-level corner
// cases, then randomized traffic against a behavioural allocator model.
module tb_sw_alloc_rr;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sw_alloc_rr_if #(.NPORT(5), .IDW(3), .EMPW(3)) bus ();

  sw_alloc_rr #(.NPORT(5), .IDW(3), .EMPW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  req, head, tail;
    logic [14:0] dest, empl;
    logic [4:0]  g, v;
    logic [14:0] s;
    logic [4:0]  a;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] pk(int f0, int f1, int f2, int f3, int f4);
    logic [14:0] r;
    r = {3'(f4), 3'(f3), 3'(f2), 3'(f1), 3'(f0)};
    return r;
  endfunction

  task automatic add(logic rst, logic [4:0] req, logic [4:0] head, logic [4:0] tail,
                     logic [14:0] dest, logic [14:0] empl, logic [4:0] g,
                     logic [4:0] v, logic [14:0] s, logic [4:0] a);
    vec_t e;
    e.rst = rst; e.req = req; e.head = head; e.tail = tail;
    e.dest = dest; e.empl = empl; e.g = g; e.v = v; e.s = s; e.a = a;
    tbl.push_back(e);
  endtask

  task automatic chk(string nm, logic [14:0] act, logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: per-output lock/owner/pointer, winners recomputed
  // from the arbitration rules each cycle.
  bit mlock[5];
  int mown[5];
  int mptr[5];
  int mwin[5];

  function automatic int fld(logic [14:0] v, int i);
    return int'((v >> (3 * i)) & 15'd7);
  endfunction

  task automatic model_eval(output logic [4:0] g, output logic [4:0] v,
                            output logic [14:0] s, output logic [4:0] a);
    bit busy[5];
    g = '0; v = '0; s = '0; a = '0;
    for (int i = 0; i < 5; i++) busy[i] = 0;
    for (int o = 0; o < 5; o++) begin
      if (mlock[o]) begin
        busy[mown[o]] = 1;
        a[o] = 1'b1;
      end
      mwin[o] = -1;
    end
    if (reset) return;
    for (int o = 0; o < 5; o++) begin
      if (fld(bus.empl, o) == 0) continue;
      if (mlock[o]) begin
        if (bus.req[mown[o]]) mwin[o] = mown[o];
      end else begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (mptr[o] + k) % 5;
          if (mwin[o] < 0 && bus.req[i] && bus.head[i] && !busy[i] && fld(bus.dest, i) == o)
            mwin[o] = i;
        end
      end
      if (mwin[o] >= 0) begin
        g[mwin[o]] = 1'b1;
        v[o] = 1'b1;
        s = s | (15'(mwin[o]) << (3 * o));
      end
    end
  endtask

  task automatic model_step();
    for (int o = 0; o < 5; o++) begin
      if (reset) begin
        mlock[o] = 0; mown[o] = 0; mptr[o] = 0;
      end else if (mwin[o] >= 0) begin
        if (mlock[o]) begin
          if (bus.tail[mown[o]]) mlock[o] = 0;
        end else begin
          mptr[o] = (mwin[o] + 1) % 5;
          if (!bus.tail[mwin[o]]) begin
            mlock[o] = 1;
            mown[o]  = mwin[o];
          end
        end
      end
    end
  endtask

  initial begin
    logic [14:0] E3, E7, D2, D4, D1;
    logic [4:0]  eg, ev, ea;
    logic [14:0] es;

    E3 = pk(3, 3, 3, 3, 3);
    E7 = pk(7, 7, 7, 7, 7);
    // reset (comb outputs must be quiet even with live requests)
    add(1, 5'b11111, 5'b11111, 5'b00000, pk(0,1,2,3,4), E3, 0, 0, 0, 0);
    // two single-flit streams to eject alternate
    D4 = pk(4, 7, 4, 7, 7);
    add(0, 5'b00101, 5'b00101, 5'b00101, D4, E3, 5'b00001, 5'b10000, 15'd0,    0);
    add(0, 5'b00101, 5'b00101, 5'b00101, D4, E3, 5'b00100, 5'b10000, 15'd8192, 0);
    add(0, 5'b00101, 5'b00101, 5'b00101, D4, E3, 5'b00001, 5'b10000, 15'd0,    0);
    add(0, 5'b00101, 5'b00101, 5'b00101, D4, E3, 5'b00100, 5'b10000, 15'd8192, 0);
    // 3-flit packet from input 1 holds output 0 against input 3's head
    add(0, 5'b01010, 5'b01010, 5'b00000, pk(7,0,7,0,7), E3, 5'b00010, 5'b00001, 15'd1, 0);
    add(0, 5'b01010, 5'b01000, 5'b00000, pk(7,0,7,0,7), E3, 5'b00010, 5'b00001, 15'd1, 5'b00001);
    add(0, 5'b01010, 5'b01000, 5'b00010, pk(7,0,7,0,7), E3, 5'b00010, 5'b00001, 15'd1, 5'b00001);
    add(0, 5'b01000, 5'b01000, 5'b01000, pk(7,7,7,0,7), E3, 5'b01000, 5'b00001, 15'd3, 0);
    // locked output 2 stalls on empl=0, then a bubble, then resumes
    D2 = pk(2, 7, 7, 7, 7);
    add(0, 5'b00001, 5'b00001, 5'b00000, D2, E3,              5'b00001, 5'b00100, 0, 0);
    add(0, 5'b00001, 5'b00000, 5'b00000, D2, pk(3,3,0,3,3),   0, 0, 0, 5'b00100);
    add(0, 5'b00001, 5'b00000, 5'b00000, D2, pk(3,3,0,3,3),   0, 0, 0, 5'b00100);
    add(0, 5'b00000, 5'b00000, 5'b00000, D2, E3,              0, 0, 0, 5'b00100);
    add(0, 5'b00001, 5'b00000, 5'b00000, D2, pk(3,3,1,3,3),   5'b00001, 5'b00100, 0, 5'b00100);
    add(0, 5'b00001, 5'b00000, 5'b00001, D2, pk(3,3,1,3,3),   5'b00001, 5'b00100, 0, 5'b00100);
    // five heads to five distinct outputs, then five tails
    add(0, 5'b11111, 5'b11111, 5'b00000, pk(4,3,2,1,0), E7, 5'b11111, 5'b11111, 15'd668, 0);
    add(0, 5'b11111, 5'b00000, 5'b11111, E7,            E7, 5'b11111, 5'b11111, 15'd668, 5'b11111);
    // reset while output 3 is locked to input 4
    D1 = pk(7, 7, 7, 7, 3);
    add(0, 5'b10000, 5'b10000, 5'b00000, D1, E3, 5'b10000, 5'b01000, 15'd2048, 0);
    add(0, 5'b10000, 5'b00000, 5'b00000, D1, E3, 5'b10000, 5'b01000, 15'd2048, 5'b01000);
    add(1, 5'b10000, 5'b00000, 5'b00000, D1, E3, 0, 0, 0, 5'b01000);
    add(0, 5'b10000, 5'b00000, 5'b00000, D1, E3, 0, 0, 0, 0);
    // eject pointer was 1 before reset; after reset input 0 must beat input 3
    add(0, 5'b01001, 5'b01001, 5'b01001, pk(4,7,7,4,7), E3, 5'b00001, 5'b10000, 0, 0);
    // dest=6 is never granted; a concurrent legal head goes through
    add(0, 5'b00011, 5'b00011, 5'b00011, pk(6,1,7,7,7), E3, 5'b00010, 5'b00010, 15'd8, 0);
    add(0, 5'b00001, 5'b00001, 5'b00001, pk(6,7,7,7,7), E3, 0, 0, 0, 0);
    add(0, 5'b00001, 5'b00001, 5'b00001, pk(6,7,7,7,7), E3, 0, 0, 0, 0);

    // unchecked preamble reset
    reset = 1'b1;
    bus.req = '0; bus.head = '0; bus.tail = '0; bus.dest = '0; bus.empl = '0;
    @(negedge clk);
    @(negedge clk);

    foreach (tbl[n]) begin
      @(negedge clk);
      reset    = tbl[n].rst;
      bus.req  = tbl[n].req;
      bus.head = tbl[n].head;
      bus.tail = tbl[n].tail;
      bus.dest = tbl[n].dest;
      bus.empl = tbl[n].empl;
      #2;
      chk($sformatf("vec%0d grant", n),     15'(bus.grant),     15'(tbl[n].g));
      chk($sformatf("vec%0d out_valid", n), 15'(bus.out_valid), 15'(tbl[n].v));
      chk($sformatf("vec%0d out_sel", n),   bus.out_sel,        tbl[n].s);
      chk($sformatf("vec%0d alloc", n),     15'(bus.alloc),     15'(tbl[n].a));
    end

    // randomized traffic, starting from a reset cycle so the model is in step
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      reset    = (c == 0) || ($urandom_range(0, 63) == 0);
      bus.req  = 5'($urandom);
      bus.head = 5'($urandom);
      bus.tail = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        bus.dest[3*i +: 3] = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                                        : 3'($urandom_range(5, 7));
        bus.empl[3*i +: 3] = 3'($urandom_range(0, 2));
      end
      #2;
      model_eval(eg, ev, es, ea);
      chk($sformatf("rnd%0d grant", c),     15'(bus.grant),     15'(eg));
      chk($sformatf("rnd%0d out_valid", c), 15'(bus.out_valid), 15'(ev));
      chk($sformatf("rnd%0d out_sel", c),   bus.out_sel,        es);
      chk($sformatf("rnd%0d alloc", c),     15'(bus.alloc),     15'(ea));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
